// File: rtl/dm_responder.sv
// Data-memory responder: valid/ready slave holding a word RAM; one response per request after LATENCY edges.
// Optional alignment checking is compiled in with `define DM_ALIGN_CHECK_EN.
module dm_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q;
  logic [AW-1:0]   idx_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem [DEPTH];

  logic            accept;
  logic            direct;
  logic            fire;
  logic            op_we;
  logic [AW-1:0]   op_idx;
  logic [3:0]      op_be;
  logic [31:0]     op_wdata;
  logic            op_err;
  logic [31:0]     old_word;
  logic [31:0]     merged;

  assign req_ready = !reset && (state_q == IDLE || state_q == RESP);
  assign rsp_valid = !reset && (state_q == RESP);
  assign accept    = req_valid && req_ready;

  // A request accepted in the RESP cycle overlaps its first latency cycle with
  // that response; with LATENCY=1 it therefore commits on the accepting edge.
  assign direct   = (LATENCY == 1) && (state_q == RESP) && accept;
  assign fire     = ((state_q == BUSY) && (cnt_q == 4'd1)) || direct;
  assign op_we    = direct ? req_we               : we_q;
  assign op_idx   = direct ? req_addr[AW+1:2]     : idx_q;
  assign op_be    = direct ? req_be               : be_q;
  assign op_wdata = direct ? req_wdata            : wdata_q;
  assign old_word = mem[op_idx];

  // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (op_be[i]) merged[8*i +: 8] = op_wdata[8*i +: 8];
    end
  end

`ifdef DM_ALIGN_CHECK_EN
  logic [1:0] lo_q;
  logic [1:0] op_lo;
  logic       be_legal;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:AW+2];
  assign op_lo = direct ? req_addr[1:0] : lo_q;

  always_comb begin
    be_legal = (op_be == 4'b1111) || (op_be == 4'b0011) || (op_be == 4'b1100) ||
               (op_be == 4'b0001) || (op_be == 4'b0010) || (op_be == 4'b0100) ||
               (op_be == 4'b1000);
    if (!op_we) begin
      op_err = (op_lo != 2'b00);
    end else begin
      op_err = !be_legal ||
               ((op_be == 4'b1111) && (op_lo != 2'b00)) ||
               (((op_be == 4'b0011) || (op_be == 4'b1100)) && op_lo[0]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       lo_q <= 2'b00;
    else if (accept) lo_q <= req_addr[1:0];
  end
`else
  logic unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign op_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = 4'(LATENCY);
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(LATENCY - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      // NOTE: the RAM is deliberately cleared on reset; this rules out a plain block-RAM mapping.
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        idx_q   <= req_addr[AW+1:2];
        be_q    <= req_be;
        wdata_q <= req_wdata;
      end
      if (fire) begin
        rsp_err   <= op_err;
        rsp_rdata <= op_err ? 32'd0 : (op_we ? merged : old_word);
        if (op_we && !op_err) mem[op_idx] <= merged;
      end
    end
  end

endmodule
